// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for a big-endian, byte-addressed, 32-bit data memory.
//
// The memory reads combinationally and writes on the falling edge of CLK. This unit accepts
// one request at a time, checks alignment and range, does read-modify-write for byte and
// halfword stores, and sign- or zero-extends loads.
//
// Optional feature: define LSU_PERF_EN to add the perf_loads/perf_stores counters.
//
// Ports:
//   CLK, RST_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_size,          store/load, size (00 byte, 01 half, 10 word, 11 illegal),
//   req_unsigned               zero-extend loads when set
//   req_addr, req_wdata        byte address, right-justified store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata                 extended load data (0 for stores/errors)
//   resp_err                   bit0 misaligned/illegal size, bit1 out of range
//   mem_RD, mem_WR             memory read/write enables (registered)
//   mem_DAddr, mem_DataIn      word-aligned address, word to write
//   mem_DataOut                word read from memory
//   perf_loads, perf_stores    (LSU_PERF_EN only) saturating completion counters
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
`ifdef LSU_PERF_EN
  output logic [15:0] perf_loads,
  output logic [15:0] perf_stores,
`endif
  output logic        mem_RD,
  output logic        mem_WR,
  output logic [31:0] mem_DAddr,
  output logic [31:0] mem_DataIn,
  input  logic [31:0] mem_DataOut
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] datain_q, datain_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic [31:0] aligned_addr;
  logic [32:0] last_byte;
  logic        err_misalign;
  logic        err_range;

  assign aligned_addr = {req_addr[31:2], 2'b00};
  // 33-bit sum so a word near the top of the address space cannot wrap into range.
  assign last_byte    = {1'b0, aligned_addr} + 33'd3;
  assign err_range    = (last_byte >= 33'(MEM_BYTES));

  always_comb begin
    err_misalign = 1'b0;
    unique case (req_size)
      2'b00:   err_misalign = 1'b0;
      2'b01:   err_misalign = req_addr[0];
      2'b10:   err_misalign = (req_addr[1:0] != 2'b00);
      default: err_misalign = 1'b1;
    endcase
  end

  // Big-endian lane shift: byte offset 0 lives in bits 31:24, halfword offset 0 in 31:16.
  function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'b00) return {~off, 3'b000};
    return off[1] ? 5'd0 : 5'd16;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] mask;
    logic [31:0] data;
    logic [4:0]  sh;
    sh   = lane_shift(size, off);
    mask = (size == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
    data = wdata & mask;
    return (old_word & ~(mask << sh)) | (data << sh);
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  off);
    logic [31:0] lane;
    lane = word >> lane_shift(size, off);
    unique case (size)
      2'b00:   return {{24{~uns & lane[7]}}, lane[7:0]};
      2'b01:   return {{16{~uns & lane[15]}}, lane[15:0]};
      default: return word;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    daddr_d      = daddr_q;
    datain_d     = datain_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          daddr_d = aligned_addr;
          if (err_misalign || err_range) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_err_d   = {err_range, err_misalign};
          end else if (req_we && (req_size == 2'b10)) begin
            state_d  = StWr;
            mem_wr_d = 1'b1;
            datain_d = req_wdata;
          end else begin
            // Loads and sub-word stores both start by reading the target word.
            state_d  = StRd;
            mem_rd_d = 1'b1;
          end
        end
      end
      StRd: begin
        if (we_q) begin
          state_d  = StWr;
          mem_wr_d = 1'b1;
          datain_d = merge_word(mem_DataOut, wdata_q, size_q, off_q);
        end else begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_rdata_d = extend_load(mem_DataOut, size_q, uns_q, off_q);
          resp_err_d   = 2'b00;
        end
      end
      StWr: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
        resp_err_d   = 2'b00;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'd0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      daddr_q      <= 32'd0;
      datain_q     <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      daddr_q      <= daddr_d;
      datain_q     <= datain_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_RD     = mem_rd_q;
  assign mem_WR     = mem_wr_q;
  assign mem_DAddr  = daddr_q;
  assign mem_DataIn = datain_q;

`ifdef LSU_PERF_EN
  logic [15:0] perf_loads_q, perf_loads_d;
  logic [15:0] perf_stores_q, perf_stores_d;
  logic        done_ok;

  assign done_ok = resp_valid_q && (resp_err_q == 2'b00);

  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    if (done_ok && !we_q && (perf_loads_q != 16'hffff))  perf_loads_d  = perf_loads_q + 16'd1;
    if (done_ok && we_q && (perf_stores_q != 16'hffff))  perf_stores_d = perf_stores_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      perf_loads_q  <= 16'd0;
      perf_stores_q <= 16'd0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        CLK;
  logic        RST_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_RD;
  logic        mem_WR;
  logic [31:0] mem_DAddr;
  logic [31:0] mem_DataIn;
  logic [31:0] mem_DataOut;

  int checks = 0;
  int errors = 0;

  // Data memory: combinational read, write on the falling edge.
  logic [31:0] mem [0:127];
  assign mem_DataOut = (mem_DAddr < 32'd512) ? mem[mem_DAddr[8:2]] : 32'hdead_beef;
  always @(negedge CLK) if (mem_WR && mem_DAddr < 32'd512) mem[mem_DAddr[8:2]] <= mem_DataIn;

  mem_access_unit #(.MEM_BYTES(512)) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_RD       (mem_RD),
    .mem_WR       (mem_WR),
    .mem_DAddr    (mem_DAddr),
    .mem_DataIn   (mem_DataIn),
    .mem_DataOut  (mem_DataOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and watches it to completion (bounded at 8 cycles).
  // lat counts rising edges from the accept edge up to the one that raises resp_valid.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic [1:0] err,
                        output int rd_cyc, output int wr_cyc,
                        output logic [31:0] wr_word, output logic [31:0] wr_addr);
    @(negedge CLK);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    lat = 1; rd_cyc = 0; wr_cyc = 0; wr_word = 32'd0; wr_addr = 32'd0;
    while (!resp_valid && lat < 8) begin
      if (mem_RD) rd_cyc++;
      if (mem_WR) begin
        wr_cyc++;
        wr_word = mem_DataIn;
        wr_addr = mem_DAddr;
      end
      @(posedge CLK);
      #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge CLK);
    #1;
  endtask

  int          lat, rdc, wrc;
  logic [31:0] rd, ww, wa;
  logic [1:0]  er;
  int          seen_resp;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    RST_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_rd_wr", {30'd0, mem_RD, mem_WR}, 32'd0);
    chk("rst_daddr", mem_DAddr, 32'd0);
    chk("rst_datain", mem_DataIn, 32'd0);
    chk("rst_rdata_err", resp_rdata | {30'd0, resp_err}, 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    // Word store then word load.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, lat, rd, er, rdc, wrc, ww, wa);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wr_cycles", 32'(wrc), 32'd1);
    chk("sw_rd_cycles", 32'(rdc), 32'd0);
    chk("sw_addr", wa, 32'h10);
    chk("sw_data", ww, 32'h1122_3344);
    chk("sw_rdata_err", rd | {30'd0, er}, 32'd0);
    chk("sw_mem", mem[4], 32'h1122_3344);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rd_cycles", 32'(rdc), 32'd1);
    chk("lw_rdata", rd, 32'h1122_3344);
    chk("ready_after", {31'd0, req_ready}, 32'd1);

    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("lb_11", rd, 32'h0000_0022);
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("lbu_10", rd, 32'h0000_0011);

    // Halfword store: read-modify-write over 0x11223344.
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_beef, lat, rd, er, rdc, wrc, ww, wa);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_rd_cycles", 32'(rdc), 32'd1);
    chk("sh_wr_cycles", 32'(wrc), 32'd1);
    chk("sh_data", ww, 32'h1122_beef);

    // Byte store 0x80 into offset 3 of 0x1122BEEF.
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'hffff_ff80, lat, rd, er, rdc, wrc, ww, wa);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_data", ww, 32'h1122_be80);
    chk("sb_mem", mem[4], 32'h1122_be80);

    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("lb_13", rd, 32'hffff_ff80);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("lbu_13", rd, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("lh_12", rd, 32'hffff_be80);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("lhu_10", rd, 32'h0000_1122);

    // Errors: no memory activity, one-cycle latency.
    do_req(1'b0, 2'b10, 1'b0, 32'h0e, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("mis_err", {30'd0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_mem_en", 32'(rdc + wrc), 32'd0);

    do_req(1'b1, 2'b10, 1'b0, 32'h1fc, 32'hcafe_f00d, lat, rd, er, rdc, wrc, ww, wa);
    chk("top_sw_err", {30'd0, er}, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h1fc, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("top_lw_rdata", rd, 32'hcafe_f00d);
    chk("top_lw_err", {30'd0, er}, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("oor_err", {30'd0, er}, 32'd2);
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_mem_en", 32'(rdc + wrc), 32'd0);
    do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("size11_err", {30'd0, er}, 32'd1);
    chk("size11_mem_en", 32'(rdc + wrc), 32'd0);
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("half_odd_err", {30'd0, er}, 32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h201, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("both_err", {30'd0, er}, 32'd3);

    // Reset during the WR cycle of a byte store, before the falling edge.
    @(negedge CLK);
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h10;
    req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    chk("abort_rd_phase", {30'd0, mem_RD, mem_WR}, 32'd2);
    @(posedge CLK);
    #1;
    chk("abort_wr_phase", {30'd0, mem_RD, mem_WR}, 32'd1);
    RST_n = 1'b0;
    #1;
    chk("abort_wr_drop", {31'd0, mem_WR}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    seen_resp = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      if (resp_valid) seen_resp++;
    end
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      #1;
      if (resp_valid) seen_resp++;
    end
    chk("abort_no_resp", 32'(seen_resp), 32'd0);
    chk("abort_mem_kept", mem[4], 32'h1122_be80);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, lat, rd, er, rdc, wrc, ww, wa);
    chk("abort_reload", rd, 32'h1122_be80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the data memory. The memory is big-endian, byte-addressed and 32-bit wide, with combinational read and write on the negedge.
- Accepts one load/store request at a time from the execute stage through a valid/ready handshake.
- Handles byte, halfword and word sizes; performs read-modify-write for sub-word stores; sign- or zero-extends loads.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 512, size of the data memory in bytes. Any access whose aligned byte address + 3 >= MEM_BYTES is out of range.

Ports:
- CLK  input  1  system clock; all state changes on posedge
- RST_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; equals (state==IDLE)
- req_we  input  1  1=store, 0=load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  2  bit0 misaligned/illegal size, bit1 out of range
- mem_RD  output  1  memory read enable
- mem_WR  output  1  memory write enable; memory samples it on negedge CLK
- mem_DAddr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_DataIn  output  32  word to write
- mem_DataOut  input  32  word read (combinational)

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset (async, RST_n=0): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_RD=0, mem_WR=0, mem_DAddr=0, mem_DataIn=0. req_ready=1 because the state is IDLE.
- Accept: at a posedge with state==IDLE and req_valid=1, latch all req_* fields.
- Error checks at accept:
  - misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - out of range: {addr[31:2],2'b00}+3 >= MEM_BYTES.
  - On any error: go to RESP with resp_err set. No mem_RD/mem_WR pulse.
- Legal load: IDLE->RD (mem_RD=1, one cycle). Capture mem_DataOut at the RD->RESP edge.
- Legal word store: IDLE->WR. mem_WR=1 for the whole cycle; mem_DataIn=req_wdata.
- Legal byte/half store: IDLE->RD (capture old word) -> WR (merged word) -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Latency from accept edge to resp_valid high:
  - error: 1 cycle
  - load / word store: 2 cycles
  - sub-word store: 3 cycles
- Lane map (big-endian):
  - byte offset 0 -> bits 31:24, 1 -> 23:16, 2 -> 15:8, 3 -> 7:0
  - half offset 0 -> 31:16, offset 2 -> 15:0
- Store merge replaces only the target lane with req_wdata[7:0] or [15:0]. Other lanes are preserved from the RD capture.
- Extension fills bits above the loaded width with the lane MSB (signed) or 0 (unsigned).
- mem_RD and mem_WR are registered from next-state. They are never both 1. Both are 0 in IDLE and RESP.
- req_valid while not IDLE is ignored; the requester holds it.
- Reset mid-operation: all outputs drop immediately and no response is issued. If reset asserts during WR before negedge CLK, the memory write does not occur.
- mem_DAddr/mem_DataIn hold their values after an access; they are don't-care while enables are 0.

Optional Feature:
- LSU_PERF_EN defined: adds outputs perf_loads[15:0] and perf_stores[15:0].
  - Each increments on the resp_valid cycle of an error-free load/store.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Word store addr 0x10, data 0x11223344; then word load 0x10 -> mem_WR one cycle with mem_DAddr=0x10; load resp_rdata=0x11223344 two cycles after accept.
- Byte load, signed, addr 0x11 after the above -> resp_rdata=0x00000022. Store byte 0x80 to 0x13, signed load 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0xBEEF to 0x12 over word 0x11223344 -> one RD cycle then WR with mem_DataIn=0x1122BEEF. resp_valid 3 cycles after accept.
- Word load addr 0x0E -> resp_err=2'b01, resp_rdata=0, resp_valid 1 cycle after accept, mem_RD/mem_WR never asserted.
- Word load addr 0x1FC (MEM_BYTES=512) succeeds; addr 0x200 -> resp_err=2'b10. size=11 -> resp_err=2'b01.
- Assert RST_n=0 during the WR cycle of a sub-word store before negedge -> mem_WR drops at once, memory word unchanged, no resp_valid, req_ready=1. With LSU_PERF_EN, counters read 0.
